// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit arbiter.
// State encodings, word length and the default abort limit.
package uart_pkg;

  localparam int unsigned WORD_LEN        = 8;
  localparam int unsigned STATE_W         = 2;
  localparam int unsigned TMO_CNT_W       = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [STATE_W-1:0] ST_LAUNCH    = 2'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_DONE = 2'd3;

  typedef logic [WORD_LEN-1:0] byte_t;

  // Saturating increment for the abort counter: it sticks at all-ones.
  function automatic logic [TMO_CNT_W-1:0] satInc(input logic [TMO_CNT_W-1:0] v);
    satInc = (v == {TMO_CNT_W{1'b1}}) ? v : v + TMO_CNT_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus between the requesters, the arbiter and the shared transmitter.
// slave: the arbiter's view; master: the surrounding client/transmitter view.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*WORD_LEN-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        xmitH;
  logic [WORD_LEN-1:0]         xmit_dataH;
  logic                        xmit_doneH;
  logic                        tx_done;
  logic [ID_W-1:0]             tx_done_id;
  logic                        tx_err;
  logic                        busy;

  modport slave (
    input  req_valid, req_data, xmit_doneH,
    output req_ready, xmitH, xmit_dataH, tx_done, tx_done_id, tx_err, busy
  );

  modport master (
    output req_valid, req_data, xmit_doneH,
    input  req_ready, xmitH, xmit_dataH, tx_done, tx_done_id, tx_err, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: searches upward from lastGnt+1 with wrap,
// returning a one-hot grant, its encoded ID and whether anything was picked.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] reqValid,
  input  logic [ID_W-1:0]    lastGnt,
  output logic [NUM_REQ-1:0] gntOneHot,
  output logic [ID_W-1:0]    gntId,
  output logic               gntValid
);

  logic [ID_W-1:0] idx;

  // Walk candidates farthest-first so the nearest valid requester wins.
  always_comb begin
    gntOneHot = '0;
    gntId     = '0;
    gntValid  = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ; k > 0; k--) begin
      idx = ID_W'((32'(lastGnt) + 32'(k)) % NUM_REQ);
      if (reqValid[idx]) begin
        gntOneHot      = '0;
        gntOneHot[idx] = 1'b1;
        gntId          = idx;
        gntValid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Optional abort timer enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_l,
  uart_tx_arbiter_if.slave   bus
);

  // Reject configurations the ID width or 8-bit timer cannot represent.
  if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 ||
      TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_cfg_err
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  logic [STATE_W-1:0]  stateQ, stateNext;
  byte_t               dataQ, selByte;
  logic [ID_W-1:0]     gntIdQ, lastGntQ;
  logic                txDoneQ, txDoneNext, txErrNext;
  logic [ID_W-1:0]     txDoneIdQ;
  logic [NUM_REQ-1:0]  pickOneHot;
  logic [ID_W-1:0]     pickId;
  logic                pickValid;
  logic                grantEn, xfer, inWait, tmoHit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .reqValid  (bus.req_valid),
    .lastGnt   (lastGntQ),
    .gntOneHot (pickOneHot),
    .gntId     (pickId),
    .gntValid  (pickValid)
  );

  // Ready only in IDLE with an idle transmitter; held low while in reset.
  assign grantEn       = (stateQ == ST_IDLE) & bus.xmit_doneH & sys_rst_l;
  assign bus.req_ready = grantEn ? pickOneHot : '0;
  assign xfer          = grantEn & pickValid;
  assign inWait        = (stateQ == ST_WAIT_BUSY) | (stateQ == ST_WAIT_DONE);

  // Byte mux for the picked requester.
  always_comb begin
    selByte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pickOneHot[i]) selByte = bus.req_data[i*WORD_LEN +: WORD_LEN];
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmoCntQ;

  assign tmoHit = inWait & (satInc(tmoCntQ) >= TMO_CNT_W'(TIMEOUT_CYC));

  // Abort timer: cleared entering LAUNCH, counts (saturating) while waiting.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      tmoCntQ <= '0;
    end else if (stateNext == ST_LAUNCH) begin
      tmoCntQ <= '0;
    end else if (inWait) begin
      tmoCntQ <= satInc(tmoCntQ);
    end
  end
`else
  assign tmoHit = 1'b0;
`endif

  // Next-state and completion/abort decode.
  always_comb begin
    stateNext  = stateQ;
    txDoneNext = 1'b0;
    txErrNext  = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (xfer) stateNext = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        stateNext = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!bus.xmit_doneH) begin
          stateNext = ST_WAIT_DONE;
        end else if (tmoHit) begin
          stateNext = ST_IDLE;
          txErrNext = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.xmit_doneH) begin
          stateNext  = ST_IDLE;
          txDoneNext = 1'b1;
        end else if (tmoHit) begin
          stateNext = ST_IDLE;
          txErrNext = 1'b1;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) stateQ <= ST_IDLE;
    else            stateQ <= stateNext;
  end

  // Capture byte and requester on a transfer; last grant starts at the top
  // so requester 0 is first after reset.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      dataQ    <= '0;
      gntIdQ   <= '0;
      lastGntQ <= ID_W'(NUM_REQ - 1);
    end else if (xfer) begin
      dataQ    <= selByte;
      gntIdQ   <= pickId;
      lastGntQ <= pickId;
    end
  end

  // Registered completion pulse and the ID reported with done/abort.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      txDoneQ   <= 1'b0;
      txDoneIdQ <= '0;
    end else begin
      txDoneQ <= txDoneNext;
      if (txDoneNext | txErrNext) txDoneIdQ <= gntIdQ;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic txErrQ;

  // Registered abort pulse.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) txErrQ <= 1'b0;
    else            txErrQ <= txErrNext;
  end

  assign bus.tx_err = txErrQ;
`else
  assign bus.tx_err = 1'b0;
`endif

  assign bus.xmitH      = (stateQ == ST_LAUNCH);
  assign bus.xmit_dataH = dataQ;
  assign bus.tx_done    = txDoneQ;
  assign bus.tx_done_id = txDoneIdQ;
  assign bus.busy       = (stateQ != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural transmitter
// (4 clocks per bit) standing in for u_xmit.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned TMO     = 20;
  localparam int unsigned BITC    = 4;

  logic sys_clk = 1'b0;
  logic sys_rst_l;
  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .bus       (bus)
  );

  // Requester stimulus
  logic [NUM_REQ-1:0] reqValid;
  logic [7:0]         reqByte [NUM_REQ];
  int                 remain  [NUM_REQ];
  logic               forceBusy, stubIgnore;

  assign bus.req_valid = reqValid;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign bus.req_data[g*8 +: 8] = reqByte[g];
  end

  // Transmitter model: drops done the cycle after sampling xmitH, sends
  // start + 8 data bits LSB first + stop, then raises done.
  logic       doneReg, serialLine, txActive;
  logic [9:0] frame;
  logic [3:0] bitIdx;
  logic [1:0] cyc;

  assign bus.xmit_doneH = doneReg & ~forceBusy;

  always @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      doneReg <= 1'b1; serialLine <= 1'b1; txActive <= 1'b0;
      frame <= '0; bitIdx <= '0; cyc <= '0;
    end else if (!txActive) begin
      if (bus.xmitH && !stubIgnore) begin
        txActive <= 1'b1; doneReg <= 1'b0;
        frame <= {1'b1, bus.xmit_dataH, 1'b0};
        serialLine <= 1'b0; bitIdx <= '0; cyc <= '0;
      end
    end else if (cyc == 2'(BITC - 1)) begin
      cyc <= '0;
      if (bitIdx == 4'd9) begin
        txActive <= 1'b0; doneReg <= 1'b1; serialLine <= 1'b1;
      end else begin
        bitIdx <= bitIdx + 4'd1;
        serialLine <= frame[1];
        frame <= {1'b1, frame[9:1]};
      end
    end else begin
      cyc <= cyc + 2'd1;
    end
  end

  // Event logs filled once per cycle
  int         grantLog[$];
  int         doneLog[$];
  int         errLog[$];
  logic [7:0] xmitLog[$];
  int         nXmit, tickNo, lastXmitTick, errTick, doneWithGrant;
  bit         multiReady;
  logic [NUM_REQ-1:0] sawReady;
  logic       serialAtNeg;

  int nChecks = 0;
  int nPass   = 0;

  function automatic logic [31:0] packIds(input int q[$]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < q.size(); i++) v = (v << 4) | 32'(q[i] + 1);
    return v;
  endfunction

  function automatic logic [31:0] packBytes(input logic [7:0] q[$]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < q.size(); i++) v = (v << 8) | 32'(q[i]);
    return v;
  endfunction

  // One clock: observe at negedge, update requesters #1 after posedge.
  task automatic tick();
    logic [NUM_REQ-1:0] hs;
    @(negedge sys_clk);
    tickNo++;
    hs = reqValid & bus.req_ready;
    serialAtNeg = serialLine;
    sawReady |= bus.req_ready;
    if ($countones(bus.req_ready) > 1) multiReady = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) if (hs[i]) grantLog.push_back(i);
    if (bus.xmitH) begin nXmit++; xmitLog.push_back(bus.xmit_dataH); lastXmitTick = tickNo; end
    if (bus.tx_done) begin doneLog.push_back(int'(bus.tx_done_id)); if (hs != '0) doneWithGrant++; end
    if (bus.tx_err) begin errLog.push_back(int'(bus.tx_done_id)); errTick = tickNo; end
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        if (remain[i] > 0) remain[i]--;
        if (remain[i] == 0) reqValid[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] b, input int n);
    remain[i] = n; reqByte[i] = b; reqValid[i] = (n > 0);
  endtask

  task automatic clear_logs();
    grantLog.delete(); doneLog.delete(); errLog.delete(); xmitLog.delete();
    nXmit = 0; doneWithGrant = 0; multiReady = 1'b0; sawReady = '0;
    lastXmitTick = 0; errTick = 0;
  endtask

  task automatic do_reset();
    sys_rst_l = 1'b0;
    forceBusy = 1'b0; stubIgnore = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'h00, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_l = 1'b1;
    clear_logs();
  endtask

  task automatic wait_dones(input int n, input int bound, output bit ok);
    int t;
    t = 0;
    while (doneLog.size() < n && t < bound) begin tick(); t++; end
    ok = (doneLog.size() >= n);
  endtask

  task automatic test_reset();
    sys_rst_l = 1'b0;
    forceBusy = 1'b0; stubIgnore = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'h00, 0);
    set_req(0, 8'h3C, 1);
    repeat (2) @(posedge sys_clk);
    #1;
    nChecks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.req_ready); else nPass++;
    nChecks++; if (bus.xmitH !== 1'b0) $display("FAIL reset_xmitH: got %b want 0", bus.xmitH); else nPass++;
    nChecks++; if (bus.xmit_dataH !== 8'h00) $display("FAIL reset_xmit_data: got %h want 00", bus.xmit_dataH); else nPass++;
    nChecks++; if (bus.tx_done !== 1'b0) $display("FAIL reset_tx_done: got %b want 0", bus.tx_done); else nPass++;
    nChecks++; if (bus.tx_err !== 1'b0) $display("FAIL reset_tx_err: got %b want 0", bus.tx_err); else nPass++;
    nChecks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else nPass++;
    nChecks++; if (bus.tx_done_id !== 2'd0) $display("FAIL reset_done_id: got %0d want 0", bus.tx_done_id); else nPass++;
  endtask

  task automatic test_single_frame();
    logic [39:0] samp;
    logic [9:0]  line;
    logic [7:0]  got;
    bit          ok;
    do_reset();
    set_req(0, 8'hA5, 1);
    for (int t = 0; t < 20 && nXmit == 0; t++) tick();
    got = (xmitLog.size() > 0) ? xmitLog[0] : 8'hxx;
    nChecks++; if (got !== 8'hA5) $display("FAIL single_xmit_data: got %h want a5", got); else nPass++;
    for (int s = 0; s < 40; s++) begin tick(); samp[s] = serialAtNeg; end
    line[0] = samp[2];
    for (int k = 0; k < 8; k++) line[k+1] = samp[4*k + 6];
    line[9] = samp[38];
    nChecks++; if (line !== {1'b1, 8'hA5, 1'b0}) $display("FAIL single_serial: got %b want %b", line, {1'b1, 8'hA5, 1'b0}); else nPass++;
    wait_dones(1, 80, ok);
    nChecks++; if (!ok) $display("FAIL single_done_timeout: got %0d dones want 1", doneLog.size()); else nPass++;
    nChecks++; if (packIds(doneLog) !== 32'h1) $display("FAIL single_done_id: got %h want 1", packIds(doneLog)); else nPass++;
    nChecks++; if (packIds(grantLog) !== 32'h1) $display("FAIL single_ready_once: got %h want 1", packIds(grantLog)); else nPass++;
    nChecks++; if (nXmit !== 1) $display("FAIL single_xmitH_cycles: got %0d want 1", nXmit); else nPass++;
    nChecks++; if ({bus.tx_done, bus.busy} !== 2'b00) $display("FAIL single_after: got done,busy=%b want 00", {bus.tx_done, bus.busy}); else nPass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    set_req(0, 8'h10, 1); set_req(1, 8'h21, 1); set_req(2, 8'h32, 1); set_req(3, 8'h43, 1);
    wait_dones(4, 400, ok);
    nChecks++; if (!ok) $display("FAIL rr_timeout: got %0d dones want 4", doneLog.size()); else nPass++;
    nChecks++; if (packIds(grantLog) !== 32'h1234) $display("FAIL rr_grant_order: got %h want 1234", packIds(grantLog)); else nPass++;
    nChecks++; if (packIds(doneLog) !== 32'h1234) $display("FAIL rr_done_order: got %h want 1234", packIds(doneLog)); else nPass++;
    nChecks++; if (packBytes(xmitLog) !== 32'h10213243) $display("FAIL rr_bytes: got %h want 10213243", packBytes(xmitLog)); else nPass++;
    nChecks++; if (nXmit !== 4) $display("FAIL rr_xmit_count: got %0d want 4", nXmit); else nPass++;
    nChecks++; if (multiReady !== 1'b0) $display("FAIL rr_ready_onehot: got %b want 0", multiReady); else nPass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    set_req(2, 8'h32, 3);
    for (int t = 0; t < 200 && grantLog.size() < 3; t++) tick();
    set_req(1, 8'h21, 1); set_req(3, 8'h43, 1);
    wait_dones(5, 400, ok);
    nChecks++; if (!ok) $display("FAIL b2b_timeout: got %0d dones want 5", doneLog.size()); else nPass++;
    nChecks++; if (packIds(grantLog) !== 32'h33342) $display("FAIL b2b_grant_order: got %h want 33342", packIds(grantLog)); else nPass++;
    nChecks++; if (packIds(doneLog) !== 32'h33342) $display("FAIL b2b_done_order: got %h want 33342", packIds(doneLog)); else nPass++;
    nChecks++; if (doneWithGrant !== 4) $display("FAIL b2b_grant_on_done: got %0d want 4", doneWithGrant); else nPass++;
  endtask

  task automatic test_xmit_busy_hold();
    bit ok;
    do_reset();
    forceBusy = 1'b1;
    set_req(3, 8'h77, 1);
    repeat (12) tick();
    nChecks++; if (sawReady !== 4'b0000) $display("FAIL hold_ready: got %b want 0000", sawReady); else nPass++;
    nChecks++; if (nXmit !== 0) $display("FAIL hold_xmitH: got %0d want 0", nXmit); else nPass++;
    nChecks++; if (bus.busy !== 1'b0) $display("FAIL hold_busy: got %b want 0", bus.busy); else nPass++;
    forceBusy = 1'b0;
    wait_dones(1, 100, ok);
    nChecks++; if (packIds(grantLog) !== 32'h4) $display("FAIL hold_grant: got %h want 4", packIds(grantLog)); else nPass++;
    nChecks++; if (packBytes(xmitLog) !== 32'h77) $display("FAIL hold_byte: got %h want 77", packBytes(xmitLog)); else nPass++;
    nChecks++; if (packIds(doneLog) !== 32'h4) $display("FAIL hold_done: got %h want 4", packIds(doneLog)); else nPass++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    set_req(1, 8'h5A, 1);
    for (int t = 0; t < 30 && bus.xmit_doneH !== 1'b0; t++) tick();
    repeat (5) tick();
    nChecks++; if (dut.stateQ !== ST_WAIT_DONE) $display("FAIL mid_in_wait_done: got %0d want %0d", dut.stateQ, ST_WAIT_DONE); else nPass++;
    set_req(0, 8'h0F, 1); set_req(1, 8'h5A, 1);
    sys_rst_l = 1'b0;
    #1;
    nChecks++; if ({bus.req_ready, bus.xmitH, bus.xmit_dataH, bus.tx_done, bus.tx_err, bus.tx_done_id} !== 17'd0)
      $display("FAIL mid_outputs_zero: got %h want 0", {bus.req_ready, bus.xmitH, bus.xmit_dataH, bus.tx_done, bus.tx_err, bus.tx_done_id}); else nPass++;
    nChecks++; if (bus.busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", bus.busy); else nPass++;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_l = 1'b1;
    wait_dones(2, 300, ok);
    nChecks++; if (packIds(grantLog) !== 32'h212) $display("FAIL mid_grant_order: got %h want 212", packIds(grantLog)); else nPass++;
    nChecks++; if (packIds(doneLog) !== 32'h12) $display("FAIL mid_done_order: got %h want 12", packIds(doneLog)); else nPass++;
  endtask

  task automatic test_timeout();
    do_reset();
    stubIgnore = 1'b1;
    set_req(2, 8'h99, 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int t = 0; t < 80 && errLog.size() == 0; t++) tick();
    nChecks++; if (packIds(errLog) !== 32'h3) $display("FAIL tmo_err_id: got %h want 3", packIds(errLog)); else nPass++;
    nChecks++; if (errTick - lastXmitTick !== int'(TMO) + 1) $display("FAIL tmo_latency: got %0d want %0d", errTick - lastXmitTick, TMO + 1); else nPass++;
    nChecks++; if (bus.busy !== 1'b0) $display("FAIL tmo_idle: got busy=%b want 0", bus.busy); else nPass++;
    nChecks++; if (doneLog.size() !== 0) $display("FAIL tmo_no_done: got %0d want 0", doneLog.size()); else nPass++;
`else
    repeat (60) tick();
    nChecks++; if (nXmit !== 1) $display("FAIL stuck_xmit_count: got %0d want 1", nXmit); else nPass++;
    nChecks++; if (dut.stateQ !== ST_WAIT_BUSY) $display("FAIL stuck_state: got %0d want %0d", dut.stateQ, ST_WAIT_BUSY); else nPass++;
    nChecks++; if (bus.busy !== 1'b1) $display("FAIL stuck_busy: got %b want 1", bus.busy); else nPass++;
    nChecks++; if (errLog.size() + doneLog.size() !== 0) $display("FAIL stuck_no_pulse: got %0d want 0", errLog.size() + doneLog.size()); else nPass++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish within 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tickNo = 0;
    clear_logs();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_back_to_back();
    test_xmit_busy_hold();
    test_reset_mid_frame();
    test_timeout();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmitter (u_xmit) between NUM_REQ byte-producing requesters. Accepts bytes over per-requester valid/ready handshakes and launches one frame at a time via the transmitter's xmitH / xmit_dataH / xmit_doneH interface. Reports completion and the requester ID of each frame. Sits in top between the client logic and iXMIT.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ)).
TIMEOUT_CYC, 255, max cycles allowed in WAIT_BUSY plus WAIT_DONE before abort (only used with the optional feature).

Ports:
sys_clk  in  1  the single clock.
sys_rst_l  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester byte-valid.
req_data  in  NUM_REQ*8  flattened bytes; requester i uses bits [8i+7:8i].
req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both high at a sys_clk edge.
xmitH  out  1  launch strobe to the transmitter.
xmit_dataH  out  8  byte to the transmitter.
xmit_doneH  in  1  transmitter idle/done level (high when idle).
tx_done  out  1  one-cycle pulse when a frame completes.
tx_done_id  out  ID_W  requester ID of the completed or aborted frame; valid while tx_done or tx_err is high.
tx_err  out  1  one-cycle abort pulse; tied to 0 without the optional feature.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, sys_rst_l=0): state=IDLE, data_q=8'h00, gnt_id=0, last_gnt=NUM_REQ-1 so requester 0 has first priority, and the timeout counter is cleared.
- Reset values of outputs: req_ready=0, xmitH=0, xmit_dataH=0, tx_done=0, tx_err=0, busy=0, tx_done_id=0.
- Reset mid-frame aborts immediately with no tx_done. u_xmit shares sys_rst_l.
- States (2-bit encoding): IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Round-robin pick among req_valid, searching from last_gnt+1 upward with wrap modulo NUM_REQ.
  - req_ready[i] is combinational: (state==IDLE) & xmit_doneH & (pick==i). At most one bit is high at a time.
  - On a transfer: data_q<=selected byte, gnt_id<=i, last_gnt<=i, state goes to LAUNCH.
  - If xmit_doneH=0 in IDLE (transmitter still busy), no grant is made.
- LAUNCH: xmitH=1 for exactly one cycle, xmit_dataH=data_q, then WAIT_BUSY.
- WAIT_BUSY: stay until xmit_doneH=0, then WAIT_DONE. The transmitter drops xmit_doneH one cycle after sampling xmitH.
- WAIT_DONE: stay until xmit_doneH=1, then IDLE, with tx_done=1 and tx_done_id=gnt_id for that one cycle (registered).
- xmit_dataH holds data_q from LAUNCH until the next grant; xmitH is a decode of the state register (no glitch paths from inputs).
- Requesters must hold req_data stable while req_valid=1 and ready=0. Dropping valid before ready is permitted; that requester is simply not granted.
- Back-to-back operation:
  - A grant may occur in the same IDLE cycle as the tx_done pulse.
  - A requester that was just served has lowest priority on the next grant.
  - A lone requester can be served every frame.
- Throughput: one frame per ~170 sys_clk (start 16 + 8x16 data + stop 16 + handshake overhead).

Optional Feature:
UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to LAUNCH and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYC, the block returns to IDLE and pulses tx_err with tx_done_id=gnt_id; no tx_done is issued.
  - The counter saturates and never wraps.
- Undefined: no counter, tx_err constant 0, and WAIT states wait indefinitely.

Decomposition:
- Shared package/header uart_pkg:
  - State encodings ST_IDLE=2'd0, ST_LAUNCH=2'd1, ST_WAIT_BUSY=2'd2, ST_WAIT_DONE=2'd3.
  - WORD_LEN=8.
  - Default TIMEOUT_CYC.
- One sub-module, rr_arbiter(NUM_REQ): combinational round-robin pick from req_valid and last_gnt, producing a one-hot grant and an encoded ID. The FSM, data register and timeout counter stay in uart_tx_arbiter.

Test Plan:
1. Reset release, req_valid=4'b0001, req_data[7:0]=8'hA5 with real u_xmit attached.
   -> req_ready[0] pulses once, xmitH high for 1 cycle with xmit_dataH=8'hA5, serial line shows 0 start, bits 1,0,1,0,0,1,0,1, then stop; tx_done pulses with tx_done_id=0.
2. All four valid with bytes 8'h10/8'h21/8'h32/8'h43 held.
   -> grant order 0,1,2,3; four tx_done pulses with IDs 0,1,2,3 in order; one xmitH per frame.
3. Only requester 2 valid for 3 frames, then requesters 1 and 3 raised together while frame 3 is in flight.
   -> after frame 3, requester 3 is granted before requester 1.
4. xmit_doneH forced 0 while in IDLE with req_valid=4'b1000.
   -> req_ready stays 0 and xmitH stays 0 until xmit_doneH returns to 1.
5. Assert sys_rst_l=0 mid-frame in WAIT_DONE.
   -> all outputs 0 asynchronously, busy=0, no tx_done; after release requester 0 is serviced first.
6. UART_TX_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=20, xmit_doneH held 1 by a stub after launch.
   -> tx_err pulses 20 cycles after LAUNCH with correct tx_done_id, FSM returns to IDLE.
   Without the macro -> FSM remains in WAIT_BUSY and tx_err stays 0.
